// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: per-stage control layouts, payload widths
// and a small occupancy helper used by pipe_stage_skid.
package pipe_pkg;

  typedef struct packed {
    logic predicted_taken;
  } if_id_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] alu_control;
    logic       alu_src;
  } id_ex_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } mem_wb_ctrl_t;

  // Payload widths are the caller's packing: 32-bit words plus 5-bit register indices.
  localparam int IF_ID_DATA_WIDTH  = 96;   // instr, pc, pc+4
  localparam int ID_EX_DATA_WIDTH  = 175;  // rd1, rd2, pc, imm, pc+4, rs1, rs2, rd
  localparam int EX_MEM_DATA_WIDTH = 101;  // alu result, write data, pc+4, rd
  localparam int MEM_WB_DATA_WIDTH = 101;  // alu result, read data, pc+4, rd

  localparam int IF_ID_CTRL_WIDTH  = $bits(if_id_ctrl_t);
  localparam int ID_EX_CTRL_WIDTH  = $bits(id_ex_ctrl_t);
  localparam int EX_MEM_CTRL_WIDTH = $bits(ex_mem_ctrl_t);
  localparam int MEM_WB_CTRL_WIDTH = $bits(mem_wb_ctrl_t);

  function automatic logic [1:0] occupancy_of(input logic main_valid, input logic skid_valid);
    return {1'b0, main_valid} + {1'b0, skid_valid};
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One pipeline slot: valid flag, payload and control field.
// Clear drops the beat and zeroes control but leaves the payload untouched.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [CTRL_WIDTH-1:0] load_ctrl,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [CTRL_WIDTH-1:0] ctrl
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      ctrl  <= load_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline-stage register with valid/ready handshake, flush, optional
// two-entry skid buffer and a saturating bubble counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4,
  parameter int SKID       = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  bubble_cnt
);

  logic                  in_fire;
  logic                  out_fire;
  logic                  main_valid;
  logic [DATA_WIDTH-1:0] main_data;
  logic [CTRL_WIDTH-1:0] main_ctrl;
  logic                  main_load;
  logic                  main_clear;
  logic [DATA_WIDTH-1:0] main_load_data;
  logic [CTRL_WIDTH-1:0] main_load_ctrl;
  logic                  skid_valid;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign occupancy = occupancy_of(main_valid, skid_valid);

  pipe_entry #(
    .DATA_WIDTH(DATA_WIDTH),
    .CTRL_WIDTH(CTRL_WIDTH)
  ) u_main (
    .clk      (clk),
    .rst      (rst),
    .load     (main_load),
    .clear    (main_clear),
    .load_data(main_load_data),
    .load_ctrl(main_load_ctrl),
    .valid    (main_valid),
    .data     (main_data),
    .ctrl     (main_ctrl)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic                  skid_load;
      logic                  skid_clear;
      logic [DATA_WIDTH-1:0] skid_data;
      logic [CTRL_WIDTH-1:0] skid_ctrl;

      // Ready depends only on the skid flop, so it never combinationally follows out_ready.
      assign in_ready = ~skid_valid;

      always_comb begin
        main_load      = 1'b0;
        main_clear     = clr;
        skid_load      = 1'b0;
        skid_clear     = clr;
        main_load_data = in_data;
        main_load_ctrl = in_ctrl;
        if (!clr) begin
          if (out_fire && skid_valid) begin
            main_load      = 1'b1;
            main_load_data = skid_data;
            main_load_ctrl = skid_ctrl;
            if (in_fire) skid_load  = 1'b1;
            else         skid_clear = 1'b1;
          end else if (in_fire && (!main_valid || out_fire)) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
          end else if (out_fire) begin
            main_clear = 1'b1;
          end
        end
      end

      pipe_entry #(
        .DATA_WIDTH(DATA_WIDTH),
        .CTRL_WIDTH(CTRL_WIDTH)
      ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load),
        .clear    (skid_clear),
        .load_data(in_data),
        .load_ctrl(in_ctrl),
        .valid    (skid_valid),
        .data     (skid_data),
        .ctrl     (skid_ctrl)
      );
    end else begin : g_single
      assign skid_valid = 1'b0;
      assign in_ready   = ~main_valid | out_ready;

      always_comb begin
        main_load_data = in_data;
        main_load_ctrl = in_ctrl;
        main_load      = in_fire & ~clr;
        main_clear     = clr | (out_fire & ~in_fire);
      end
    end
  endgenerate

  // Counts cycles where downstream could take a beat but none is offered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt <= '0;
    end else if (out_ready && !out_valid && !(&bubble_cnt)) begin
      bubble_cnt <= bubble_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomised and directed bench for pipe_stage_skid: one SKID=1 and one SKID=0
// instance, each compared every cycle against a queue-based FIFO model.
module tb_pipe_stage_skid;

  localparam int DW      = 16;
  localparam int CW      = 4;
  localparam int NW      = 4;
  localparam int CNT_MAX = (1 << NW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;

  logic          s1_in_valid = 1'b0, s1_in_ready, s1_out_valid, s1_out_ready = 1'b0;
  logic [DW-1:0] s1_in_data = '0, s1_out_data;
  logic [CW-1:0] s1_in_ctrl = '0, s1_out_ctrl;
  logic [1:0]    s1_occupancy;
  logic [NW-1:0] s1_bubble_cnt;

  logic          s0_in_valid = 1'b0, s0_in_ready, s0_out_valid, s0_out_ready = 1'b0;
  logic [DW-1:0] s0_in_data = '0, s0_out_data;
  logic [CW-1:0] s0_in_ctrl = '0, s0_out_ctrl;
  logic [1:0]    s0_occupancy;
  logic [NW-1:0] s0_bubble_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW+CW-1:0] q1[$];
  logic [DW+CW-1:0] q0[$];
  int   cnt1, cnt0;
  logic fire1, fire0;

  pipe_stage_skid #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .SKID(1), .CNT_WIDTH(NW)) dut_skid (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(s1_in_valid), .in_ready(s1_in_ready), .in_data(s1_in_data), .in_ctrl(s1_in_ctrl),
    .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_data(s1_out_data),
    .out_ctrl(s1_out_ctrl), .occupancy(s1_occupancy), .bubble_cnt(s1_bubble_cnt)
  );

  pipe_stage_skid #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .SKID(0), .CNT_WIDTH(NW)) dut_single (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_data(s0_in_data), .in_ctrl(s0_in_ctrl),
    .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_data(s0_out_data),
    .out_ctrl(s0_out_ctrl), .occupancy(s0_occupancy), .bubble_cnt(s0_bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    q1.delete();
    q0.delete();
    cnt1 = 0;
    cnt0 = 0;
  endtask

  // Compare both DUTs against the FIFO model; the head of each queue is the main entry.
  task automatic checkModel();
    logic [DW+CW-1:0] h1, h0;
    h1 = (q1.size() != 0) ? q1[0] : '0;
    h0 = (q0.size() != 0) ? q0[0] : '0;
    checkOutput("s1_in_ready",  32'(s1_in_ready),   32'(q1.size() < 2));
    checkOutput("s1_out_valid", 32'(s1_out_valid),  32'(q1.size() != 0));
    checkOutput("s1_out_ctrl",  32'(s1_out_ctrl),   32'(h1[DW+CW-1:DW]));
    checkOutput("s1_occupancy", 32'(s1_occupancy),  32'(q1.size()));
    checkOutput("s1_bubble",    32'(s1_bubble_cnt), 32'(cnt1));
    if (q1.size() != 0) checkOutput("s1_out_data", 32'(s1_out_data), 32'(h1[DW-1:0]));
    checkOutput("s0_in_ready",  32'(s0_in_ready),   32'((q0.size() == 0) || s0_out_ready));
    checkOutput("s0_out_valid", 32'(s0_out_valid),  32'(q0.size() != 0));
    checkOutput("s0_out_ctrl",  32'(s0_out_ctrl),   32'(h0[DW+CW-1:DW]));
    checkOutput("s0_occupancy", 32'(s0_occupancy),  32'(q0.size()));
    checkOutput("s0_bubble",    32'(s0_bubble_cnt), 32'(cnt0));
    if (q0.size() != 0) checkOutput("s0_out_data", 32'(s0_out_data), 32'(h0[DW-1:0]));
  endtask

  // Called at a falling edge: drive, check, clock once, advance the model, return to falling edge.
  task automatic applyStimulus(
    input logic v1, input logic [DW-1:0] d1, input logic [CW-1:0] c1, input logic r1,
    input logic v0, input logic [DW-1:0] d0, input logic [CW-1:0] c0, input logic r0,
    input logic fl);
    logic o1, o0, b1, b0;
    s1_in_valid = v1; s1_in_data = d1; s1_in_ctrl = c1; s1_out_ready = r1;
    s0_in_valid = v0; s0_in_data = d0; s0_in_ctrl = c0; s0_out_ready = r0;
    clr = fl;
    #1;
    checkModel();
    fire1 = v1 && (q1.size() < 2);
    fire0 = v0 && ((q0.size() == 0) || r0);
    o1    = r1 && (q1.size() != 0);
    o0    = r0 && (q0.size() != 0);
    b1    = r1 && (q1.size() == 0) && (cnt1 < CNT_MAX);
    b0    = r0 && (q0.size() == 0) && (cnt0 < CNT_MAX);
    @(posedge clk);
    if (b1) cnt1++;
    if (b0) cnt0++;
    if (fl) begin
      q1.delete();
      q0.delete();
    end else begin
      if (o1) void'(q1.pop_front());
      if (fire1) q1.push_back({c1, d1});
      if (o0) void'(q0.pop_front());
      if (fire0) q0.push_back({c0, d0});
    end
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_s1_valid"},  32'(s1_out_valid),  32'd0);
    checkOutput({tag, "_s1_occ"},    32'(s1_occupancy),  32'd0);
    checkOutput({tag, "_s1_ctrl"},   32'(s1_out_ctrl),   32'd0);
    checkOutput({tag, "_s1_bubble"}, 32'(s1_bubble_cnt), 32'd0);
    checkOutput({tag, "_s1_ready"},  32'(s1_in_ready),   32'd1);
    checkOutput({tag, "_s0_valid"},  32'(s0_out_valid),  32'd0);
    checkOutput({tag, "_s0_occ"},    32'(s0_occupancy),  32'd0);
    checkOutput({tag, "_s0_ctrl"},   32'(s0_out_ctrl),   32'd0);
    checkOutput({tag, "_s0_bubble"}, 32'(s0_bubble_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic          h1, h0;
    logic          v1, v0, r1, r0, fl;
    logic [DW-1:0] d1, d0;
    logic [CW-1:0] c1, c0;

    modelReset();
    #2 rst = 1'b0;
    @(negedge clk);
    #1;
    checkResetState("reset");
    checkOutput("reset_s1_data", 32'(s1_out_data), 32'd0);
    checkOutput("reset_s0_data", 32'(s0_out_data), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] full throughput");
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, DW'(i), CW'(i), 1'b1, 1'b1, DW'(i), CW'(i), 1'b1, 1'b0);
    checkOutput("thru_s1_occ",    32'(s1_occupancy),  32'd1);
    checkOutput("thru_s1_bubble", 32'(s1_bubble_cnt), 32'd1);
    checkOutput("thru_s0_bubble", 32'(s0_bubble_cnt), 32'd1);
    checkOutput("thru_s1_last",   32'(s1_out_data),   32'd15);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);

    $display("[TB] stall with skid");
    applyStimulus(1'b1, 16'hA1, 4'h1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'hA2, 4'h2, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'hA3, 4'h3, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("stall_occ",   32'(s1_occupancy), 32'd2);
    checkOutput("stall_ready", 32'(s1_in_ready),  32'd0);
    checkOutput("stall_out0",  32'(s1_out_data),  32'hA1);
    applyStimulus(1'b1, 16'hA3, 4'h3, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("stall_out1",  32'(s1_out_data),  32'hA2);
    applyStimulus(1'b1, 16'hA3, 4'h3, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("stall_out2",  32'(s1_out_data),  32'hA3);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);

    $display("[TB] flush");
    applyStimulus(1'b1, 16'hB1, 4'b1011, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hB2, 4'b1011, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hFF, 4'b1011, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("flush_occ",  32'(s1_occupancy), 32'd0);
    checkOutput("flush_ctrl", 32'(s1_out_ctrl),  32'd0);
    applyStimulus(1'b1, 16'hB3, 4'b1011, 1'b0, 1'b1, 16'hC1, 4'b1011, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hFF, 4'b1111, 1'b1, 1'b1, 16'hFF, 4'b1111, 1'b1, 1'b1);
    checkOutput("flush_fire_s1_occ", 32'(s1_occupancy), 32'd0);
    checkOutput("flush_fire_s0_occ", 32'(s0_occupancy), 32'd0);
    checkOutput("flush_fire_s0_ctl", 32'(s0_out_ctrl),  32'd0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("flush_no_ff_s1", 32'(s1_out_valid), 32'd0);
    checkOutput("flush_no_ff_s0", 32'(s0_out_valid), 32'd0);

    $display("[TB] random traffic");
    h1 = 1'b0; h0 = 1'b0;
    v1 = 1'b0; v0 = 1'b0; d1 = '0; d0 = '0; c1 = '0; c0 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!h1) begin
        v1 = ($urandom_range(0, 3) != 0);
        d1 = DW'($urandom);
        c1 = CW'($urandom);
      end
      if (!h0) begin
        v0 = ($urandom_range(0, 3) != 0);
        d0 = DW'($urandom);
        c0 = CW'($urandom);
      end
      r1 = ($urandom_range(0, 2) != 0);
      r0 = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 24) == 0);
      applyStimulus(v1, d1, c1, r1, v0, d0, c0, r0, fl);
      h1 = v1 && !fire1;
      h0 = v0 && !fire0;
    end

    $display("[TB] asynchronous reset mid-stream");
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'hD1, 4'hD, 1'b0, 1'b1, 16'hE1, 4'hE, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hD2, 4'hD, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("pre_reset_occ", 32'(s1_occupancy), 32'd2);
    #2 rst = 1'b0;
    #1;
    checkResetState("async_reset");
    modelReset();
    s1_in_valid = 1'b0; s0_in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] bubble counter saturation");
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("sat_s1", 32'(s1_bubble_cnt), 32'd15);
    checkOutput("sat_s0", 32'(s0_bubble_cnt), 32'd15);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("sat_hold_s1", 32'(s1_bubble_cnt), 32'd15);

    $display("[TB] combinational ready without skid");
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 16'h55, 4'h5, 1'b0, 1'b0);
    s0_in_valid  = 1'b1;
    s0_in_data   = 16'h66;
    s0_in_ctrl   = 4'h6;
    s0_out_ready = 1'b0;
    #1;
    checkOutput("comb_ready_lo", 32'(s0_in_ready), 32'd0);
    s0_out_ready = 1'b1;
    #1;
    checkOutput("comb_ready_hi", 32'(s0_in_ready), 32'd1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 16'h66, 4'h6, 1'b1, 1'b0);
    checkOutput("comb_reload_data", 32'(s0_out_data),  32'h66);
    checkOutput("comb_reload_occ",  32'(s0_occupancy), 32'd1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
